// File: rtl/adc_sampler.sv
// Periodic MCP3001-style SPI ADC reader with a 2^AVG_LOG2 boxcar averager.
// adc_o feeds the 10-bit ADC input of the pt100 temperature converter.
module adc_sampler #(
  parameter int ADC_RES       = 10,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int AVG_LOG2      = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               miso_i,
  output logic               sclk_o,
  output logic               cs_no,
  output logic [ADC_RES-1:0] sample_o,
  output logic [ADC_RES-1:0] adc_o,
  output logic               valid_o,
  output logic               overrun_o
);

  localparam int ACC_W = ADC_RES + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_FIRST  = 4'd3;   // edges 1-3: sample + null bits
  localparam logic [3:0]       BIT_LAST   = 4'd12;

  // Truncating divide of the boxcar sum by the sample count.
  function automatic logic [ADC_RES-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] shifted;
    shifted = sum >> AVG_LOG2;
    return shifted[ADC_RES-1:0];
  endfunction

  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic               sclk_q, sclk_d;
  logic [ADC_RES-1:0] shift_q, shift_d;
  logic [ADC_RES-1:0] sample_q, sample_d;
  logic [ADC_RES-1:0] adc_q, adc_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               trigger;
  logic               div_last;
  logic [ACC_W-1:0]   sum;

  always_comb begin
    timer_d  = '0;
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    adc_d    = adc_q;
    valid_d  = 1'b0;
    ovr_d    = ovr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    trigger  = enable_i && (timer_q == TIMER_LAST);
    div_last = (div_q == DIV_LAST);
    sum      = acc_q + ACC_W'(shift_q);

    if (enable_i && !trigger) timer_d = timer_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        sclk_d = 1'b0;
        if (!enable_i) begin
          acc_d = '0;
          cnt_d = '0;
        end
        if (trigger) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            // Rising SCLK edge: ADC data has been stable since the last falling edge.
            if (bit_q >= BIT_FIRST) shift_d = {shift_q[ADC_RES-2:0], miso_i};
          end else if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        if (div_last) begin
          div_d    = '0;
          state_d  = ST_IDLE;
          sample_d = shift_q;
          if (cnt_q == CNT_LAST) begin
            adc_d   = avg_trunc(sum);
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase

    if (trigger && (state_q != ST_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q  <= '0;
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      shift_q  <= '0;
      sample_q <= '0;
      adc_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      timer_q  <= timer_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      adc_q    <= adc_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign cs_no     = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
  assign sample_o  = sample_q;
  assign adc_o     = adc_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule
